// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream types: FIFO flag bundle and the default credit pool size
// for the TCDM load buffer.
package hwpe_stream_package;

  typedef struct packed {
    logic       empty;
    logic       full;
    logic [7:0] push_pointer;
    logic [7:0] pop_pointer;
  } flags_fifo_t;

  localparam int unsigned HWPE_TCDM_LOAD_MAX_OUTSTANDING = 8;

endpackage

// File: rtl/hwpe_stream_fifo_flat.sv
// Registered (non fall-through) FIFO with flat ports, synchronous active-low
// reset and soft clear. Read data reads as zero while the FIFO is empty.
module hwpe_stream_fifo_flat #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]           wr_ptr_q;
  logic [PW:0]           rd_ptr_q;
  logic                  do_push;
  logic                  do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/hwpe_stream_tcdm_fifo_load_credit.sv
// Credit-based TCDM load buffer: requests are issued only while a response slot
// is reserved. Optional perf counters under HWPE_STREAM_TCDM_LOAD_PERF_EN.
module hwpe_stream_tcdm_fifo_load_credit
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = FIFO_DEPTH,
  parameter int unsigned SIDECH_WIDTH    = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  output flags_fifo_t                          flags_o,
  input  logic                                 slave_req_i,
  output logic                                 slave_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                slave_add_i,
  input  logic [SIDECH_WIDTH-1:0]              sidech_i,
  output logic [DATA_WIDTH-1:0]                slave_r_data_o,
  output logic                                 slave_r_valid_o,
  input  logic                                 ready_i,
  output logic [SIDECH_WIDTH-1:0]              sidech_o,
  output logic                                 master_req_o,
  input  logic                                 master_gnt_i,
  output logic [ADDR_WIDTH-1:0]                master_add_o,
  output logic                                 master_wen_o,
  output logic [DATA_WIDTH/8-1:0]              master_be_o,
  output logic [DATA_WIDTH-1:0]                master_data_o,
  input  logic [DATA_WIDTH-1:0]                master_r_data_i,
  input  logic                                 master_r_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] credits_o,
  output logic [31:0]                          perf_stall_o,
  output logic [31:0]                          perf_resp_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned RQW = ADDR_WIDTH + SIDECH_WIDTH;
  localparam int unsigned RSW = DATA_WIDTH + SIDECH_WIDTH;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(MAX_OUTSTANDING);

  logic [RQW-1:0]          req_wdata, req_rdata;
  logic                    req_full, req_empty, req_push, req_valid;
  logic [RSW-1:0]          resp_wdata, resp_rdata;
  logic                    resp_full, resp_empty, resp_push, resp_pop;
  logic                    grant;
  logic                    pend_q;
  logic [SIDECH_WIDTH-1:0] pend_sidech_q;
  logic [CW-1:0]           credits_q;

  assign req_wdata   = {slave_add_i, sidech_i};
  assign slave_gnt_o = ~req_full;
  assign req_push    = slave_req_i & slave_gnt_o;
  assign req_valid   = ~req_empty;

  hwpe_stream_fifo_flat #(
    .DATA_WIDTH ( RQW        ),
    .FIFO_DEPTH ( FIFO_DEPTH )
  ) i_req_fifo (
    .clk_i   ( clk_i     ),
    .rst_ni  ( rst_ni    ),
    .clear_i ( clear_i   ),
    .push_i  ( req_push  ),
    .data_i  ( req_wdata ),
    .pop_i   ( grant     ),
    .data_o  ( req_rdata ),
    .full_o  ( req_full  ),
    .empty_o ( req_empty )
  );

  assign master_req_o  = req_valid & (credits_q != '0);
  assign master_add_o  = req_rdata[RQW-1:SIDECH_WIDTH];
  assign master_wen_o  = 1'b1;
  assign master_be_o   = '1;
  assign master_data_o = '0;
  assign grant         = master_req_o & master_gnt_i;

  // TCDM answers exactly one cycle after grant; anything else is not ours.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      pend_q        <= 1'b0;
      pend_sidech_q <= '0;
    end else begin
      pend_q <= grant;
      if (grant) pend_sidech_q <= req_rdata[SIDECH_WIDTH-1:0];
    end
  end

  assign resp_push  = pend_q & master_r_valid_i;
  assign resp_wdata = {master_r_data_i, pend_sidech_q};

  hwpe_stream_fifo_flat #(
    .DATA_WIDTH ( RSW        ),
    .FIFO_DEPTH ( FIFO_DEPTH )
  ) i_resp_fifo (
    .clk_i   ( clk_i      ),
    .rst_ni  ( rst_ni     ),
    .clear_i ( clear_i    ),
    .push_i  ( resp_push  ),
    .data_i  ( resp_wdata ),
    .pop_i   ( resp_pop   ),
    .data_o  ( resp_rdata ),
    .full_o  ( resp_full  ),
    .empty_o ( resp_empty )
  );

  assign slave_r_valid_o = ~resp_empty;
  assign slave_r_data_o  = resp_rdata[RSW-1:SIDECH_WIDTH];
  assign sidech_o        = resp_rdata[SIDECH_WIDTH-1:0];
  assign resp_pop        = slave_r_valid_o & ready_i;

  // Grant only happens with credits left and a pop implies one outstanding,
  // so the counter stays within 0..MAX_OUTSTANDING by construction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      credits_q <= CREDITS_MAX;
    end else begin
      case ({grant, resp_pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign credits_o = credits_q;

  always_comb begin
    flags_o       = '0;
    flags_o.empty = req_empty & resp_empty & ~pend_q & (credits_q == CREDITS_MAX);
    flags_o.full  = req_full;
  end

`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
  logic [31:0] perf_stall_q, perf_resp_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      perf_stall_q <= '0;
      perf_resp_q  <= '0;
    end else begin
      if (req_valid && (credits_q == '0) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (resp_pop && (perf_resp_q != '1))
        perf_resp_q <= perf_resp_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_resp_o  = perf_resp_q;
`else
  assign perf_stall_o = '0;
  assign perf_resp_o  = '0;
`endif

  resp_no_overflow_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(resp_push && resp_full && !clear_i)
  );

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_load_credit.sv
// Bench for the credit-based TCDM load buffer: queue-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hwpe_stream_tcdm_fifo_load_credit;
  import hwpe_stream_package::*;

  localparam int DW = 32, AW = 32, DEPTH = 8, MAXO = 4, SW = 1;
  localparam int CW = $clog2(MAXO+1);

  logic            clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
  flags_fifo_t     flags_o;
  logic            slave_req_i = 1'b0, slave_gnt_o;
  logic [AW-1:0]   slave_add_i = '0;
  logic [SW-1:0]   sidech_i = '0, sidech_o;
  logic [DW-1:0]   slave_r_data_o;
  logic            slave_r_valid_o, ready_i = 1'b0;
  logic            master_req_o, master_gnt_i = 1'b0, master_wen_o;
  logic [AW-1:0]   master_add_o;
  logic [DW/8-1:0] master_be_o;
  logic [DW-1:0]   master_data_o, master_r_data_i = '0;
  logic            master_r_valid_i = 1'b0;
  logic [CW-1:0]   credits_o;
  logic [31:0]     perf_stall_o, perf_resp_o;

  hwpe_stream_tcdm_fifo_load_credit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .SIDECH_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .flags_o(flags_o),
    .slave_req_i(slave_req_i), .slave_gnt_o(slave_gnt_o), .slave_add_i(slave_add_i),
    .sidech_i(sidech_i), .slave_r_data_o(slave_r_data_o), .slave_r_valid_o(slave_r_valid_o),
    .ready_i(ready_i), .sidech_o(sidech_o), .master_req_o(master_req_o),
    .master_gnt_i(master_gnt_i), .master_add_o(master_add_o), .master_wen_o(master_wen_o),
    .master_be_o(master_be_o), .master_data_o(master_data_o),
    .master_r_data_i(master_r_data_i), .master_r_valid_i(master_r_valid_i),
    .credits_o(credits_o), .perf_stall_o(perf_stall_o), .perf_resp_o(perf_resp_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TCDM memory stand-in: answers one cycle after each grant.
  function automatic logic [31:0] tcdm_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a * 32'd3 + 32'h1234_0001);
  endfunction

  always @(posedge clk_i) begin
    logic          g;
    logic [31:0]   a;
    g = master_req_o & master_gnt_i;
    a = master_add_o;
    #1;
    master_r_valid_i = g;
    master_r_data_i  = g ? tcdm_word(a) : 32'h0BAD_0BAD;
  end

  // Reference model: request queue, response queue, outstanding count.
  typedef struct { logic [31:0] a; logic sc; } req_t;
  typedef struct { logic [31:0] d; logic sc; } rsp_t;
  req_t m_req[$];
  rsp_t m_rsp[$];
  int   m_out = 0, m_stall = 0, m_resp = 0;
  bit   m_pend = 0, m_live = 0;
  logic m_pend_sc = 1'b0;

  function bit p_gnt();  return m_req.size() < DEPTH; endfunction
  function bit p_mreq(); return (m_req.size() > 0) && (m_out < MAXO); endfunction
  function logic [31:0] p_add(); if (m_req.size() > 0) return m_req[0].a; return 32'h0; endfunction
  function logic [31:0] p_rdata(); if (m_rsp.size() > 0) return m_rsp[0].d; return 32'h0; endfunction
  function logic p_rsc(); if (m_rsp.size() > 0) return m_rsp[0].sc; return 1'b0; endfunction

  always @(posedge clk_i) begin
    bit   push, grant, pop;
    req_t hd;
    rsp_t nr;
    if (!rst_ni || clear_i) begin
      m_req.delete(); m_rsp.delete();
      m_out = 0; m_pend = 0; m_pend_sc = 1'b0; m_stall = 0; m_resp = 0;
      if (!rst_ni) m_live = 1;
    end else begin
      push  = slave_req_i && p_gnt();
      grant = p_mreq() && master_gnt_i;
      pop   = (m_rsp.size() > 0) && ready_i;
      if ((m_req.size() > 0) && (m_out == MAXO)) m_stall++;
      if (pop) begin void'(m_rsp.pop_front()); m_out--; m_resp++; end
      if (m_pend && master_r_valid_i) begin
        nr.d = master_r_data_i; nr.sc = m_pend_sc; m_rsp.push_back(nr);
      end
      if (grant) begin hd = m_req.pop_front(); m_pend_sc = hd.sc; m_out++; end
      m_pend = grant;
      if (push) begin hd.a = slave_add_i; hd.sc = sidech_i[0]; m_req.push_back(hd); end
    end
  end

  always @(negedge clk_i) begin
    if (m_live && rst_ni) begin
      chk("slave_gnt", slave_gnt_o, p_gnt());
      chk("master_req", master_req_o, p_mreq());
      chk("master_add", master_add_o, p_add());
      chk("r_valid", slave_r_valid_o, m_rsp.size() > 0);
      chk("r_data", slave_r_data_o, p_rdata());
      chk("sidech_o", sidech_o, p_rsc());
      chk("credits", credits_o, MAXO - m_out);
      chk("flags_empty", flags_o.empty,
          (m_req.size() == 0) && (m_rsp.size() == 0) && !m_pend && (m_out == 0));
      chk("flags_full", flags_o.full, m_req.size() == DEPTH);
      chk("master_wen", master_wen_o, 1);
      chk("master_be", master_be_o, 4'hF);
      chk("master_data", master_data_o, 0);
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
      chk("perf_stall", perf_stall_o, m_stall);
      chk("perf_resp", perf_resp_o, m_resp);
`else
      chk("perf_stall", perf_stall_o, 0);
      chk("perf_resp", perf_resp_o, 0);
`endif
    end
  end

  int cyc = 0, gcnt = 0, pcnt = 0;
  int pop_cyc[$];
  always @(posedge clk_i) begin
    cyc++;
    if (master_req_o && master_gnt_i) gcnt++;
    if (slave_r_valid_o && ready_i) begin pcnt++; pop_cyc.push_back(cyc); end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int k = 0;
    while (pcnt < target && k < budget) begin tick(); k++; end
    chk(name, pcnt, target);
  endtask

  initial begin
    int g0, p0;
    tick(); tick();
    rst_ni = 1'b1;
    chk("rst slave_gnt", slave_gnt_o, 1);
    chk("rst master_req", master_req_o, 0);
    chk("rst r_valid", slave_r_valid_o, 0);
    chk("rst r_data", slave_r_data_o, 0);
    chk("rst sidech_o", sidech_o, 0);
    chk("rst empty", flags_o.empty, 1);
    chk("rst credits", credits_o, MAXO);

    // single read, minimum latency
    ready_i = 1'b1; master_gnt_i = 1'b1;
    slave_req_i = 1'b1; slave_add_i = 32'h100; sidech_i = 1'b1;
    tick();
    slave_req_i = 1'b0; slave_add_i = '0; sidech_i = 1'b0;
    chk("t1 master_req", master_req_o, 1);
    chk("t1 master_add", master_add_o, 32'h100);
    tick();
    chk("t2 r_valid", slave_r_valid_o, 0);
    tick();
    chk("t3 r_valid", slave_r_valid_o, 1);
    chk("t3 r_data", slave_r_data_o, 32'hDEADBEEF);
    chk("t3 sidech", sidech_o, 1);
    tick();
    chk("single credits back", credits_o, MAXO);

    // credit exhaustion
    ready_i = 1'b0; g0 = gcnt; p0 = pcnt;
    for (int i = 0; i < 6; i++) begin
      slave_req_i = 1'b1; slave_add_i = 32'h2000 + 32'(i*4); sidech_i = 1'(i & 1);
      tick();
    end
    slave_req_i = 1'b0;
    repeat (4) tick();
    chk("exh grants", gcnt - g0, 4);
    chk("exh master_req", master_req_o, 0);
    chk("exh credits", credits_o, 0);
    ready_i = 1'b1;
    wait_pops(p0 + 6, 40, "exh responses");

    // back-to-back streaming
    pop_cyc.delete(); p0 = pcnt;
    for (int i = 0; i < 32; i++) begin
      slave_req_i = 1'b1; slave_add_i = 32'h3000 + 32'(i*4); sidech_i = 1'(i & 1);
      tick();
    end
    slave_req_i = 1'b0;
    wait_pops(p0 + 32, 60, "b2b count");
    if (pop_cyc.size() >= 32) chk("b2b consecutive", pop_cyc[31] - pop_cyc[0], 31);
    repeat (2) tick();
    chk("b2b empty", flags_o.empty, 1);

    // grant and pop in the same cycle at credits=2
    ready_i = 1'b0; p0 = pcnt;
    slave_req_i = 1'b1; slave_add_i = 32'h4000; sidech_i = 1'b1; tick();
    slave_add_i = 32'h4004; sidech_i = 1'b0; tick();
    slave_req_i = 1'b0; tick();
    slave_req_i = 1'b1; slave_add_i = 32'h4008; sidech_i = 1'b1; tick();
    slave_req_i = 1'b0;
    chk("simul pre credits", credits_o, 2);
    chk("simul pre master_req", master_req_o, 1);
    chk("simul pre r_valid", slave_r_valid_o, 1);
    ready_i = 1'b1;
    tick();
    chk("simul credits", credits_o, 2);
    wait_pops(p0 + 3, 20, "simul drain");
    repeat (2) tick();

    // clear the cycle after a grant drops the returning response
    slave_req_i = 1'b1; slave_add_i = 32'h5000; sidech_i = 1'b1; tick();
    slave_req_i = 1'b0; tick();
    clear_i = 1'b1; tick();
    clear_i = 1'b0;
    chk("clr r_valid", slave_r_valid_o, 0);
    chk("clr credits", credits_o, MAXO);
    tick();
    chk("clr r_valid later", slave_r_valid_o, 0);
    chk("clr empty", flags_o.empty, 1);

    // exactly five credit-stall cycles
    ready_i = 1'b0; clear_i = 1'b1; tick(); clear_i = 1'b0;
    p0 = pcnt;
    for (int i = 0; i < 5; i++) begin
      slave_req_i = 1'b1; slave_add_i = 32'h6000 + 32'(i*4); sidech_i = 1'(i & 1);
      tick();
    end
    slave_req_i = 1'b0;
    chk("perf pre stall", perf_stall_o, 0);
    repeat (5) tick();
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
    chk("perf stall 5", perf_stall_o, 5);
`else
    chk("perf stall off", perf_stall_o, 0);
`endif
    ready_i = 1'b1;
    wait_pops(p0 + 5, 30, "perf drain");
    repeat (3) tick();
    chk("final empty", flags_o.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
